// File: rtl/instr_decoder_pkg.sv
// Shared FunctionUnit select codes plus the small set of types and helpers
// the decoder files use to talk about instruction words.
package instr_decoder_pkg;

  // Format I (two-operand) FunctionUnit codes, word and byte flavours
  localparam logic [15:0] FS_MOV    = 16'h0040;
  localparam logic [15:0] FS_MOV_B  = 16'h0041;
  localparam logic [15:0] FS_ADD    = 16'h0050;
  localparam logic [15:0] FS_ADD_B  = 16'h0051;
  localparam logic [15:0] FS_ADDC   = 16'h0060;
  localparam logic [15:0] FS_ADDC_B = 16'h0061;
  localparam logic [15:0] FS_SUBC   = 16'h0070;
  localparam logic [15:0] FS_SUBC_B = 16'h0071;
  localparam logic [15:0] FS_SUB    = 16'h0080;
  localparam logic [15:0] FS_SUB_B  = 16'h0081;
  localparam logic [15:0] FS_CMP    = 16'h0090;
  localparam logic [15:0] FS_CMP_B  = 16'h0091;
  localparam logic [15:0] FS_DADD   = 16'h00A0;
  localparam logic [15:0] FS_DADD_B = 16'h00A1;
  localparam logic [15:0] FS_BIT    = 16'h00B0;
  localparam logic [15:0] FS_BIT_B  = 16'h00B1;
  localparam logic [15:0] FS_BIC    = 16'h00C0;
  localparam logic [15:0] FS_BIC_B  = 16'h00C1;
  localparam logic [15:0] FS_BIS    = 16'h00D0;
  localparam logic [15:0] FS_BIS_B  = 16'h00D1;
  localparam logic [15:0] FS_XOR    = 16'h00E0;
  localparam logic [15:0] FS_XOR_B  = 16'h00E1;
  localparam logic [15:0] FS_AND    = 16'h00F0;
  localparam logic [15:0] FS_AND_B  = 16'h00F1;

  // Format II (single-operand) FunctionUnit codes; SWPB/SXT/CALL/RETI are word-only
  localparam logic [15:0] FS_RRC    = 16'h0100;
  localparam logic [15:0] FS_RRC_B  = 16'h0101;
  localparam logic [15:0] FS_SWPB   = 16'h0110;
  localparam logic [15:0] FS_RRA    = 16'h0120;
  localparam logic [15:0] FS_RRA_B  = 16'h0121;
  localparam logic [15:0] FS_SXT    = 16'h0130;
  localparam logic [15:0] FS_PUSH   = 16'h0140;
  localparam logic [15:0] FS_PUSH_B = 16'h0141;
  localparam logic [15:0] FS_CALL   = 16'h0150;
  localparam logic [15:0] FS_RETI   = 16'h0160;

  // Format II opcode field values (iw[9:7])
  localparam logic [2:0] OP2_RRC  = 3'd0;
  localparam logic [2:0] OP2_SWPB = 3'd1;
  localparam logic [2:0] OP2_RRA  = 3'd2;
  localparam logic [2:0] OP2_SXT  = 3'd3;
  localparam logic [2:0] OP2_PUSH = 3'd4;
  localparam logic [2:0] OP2_CALL = 3'd5;
  localparam logic [2:0] OP2_RETI = 3'd6;
  localparam logic [2:0] OP2_BAD  = 3'd7;

  // Instruction word classes produced by the classifier
  typedef enum logic [1:0] {
    FMT_I       = 2'd0,
    FMT_II      = 2'd1,
    FMT_JUMP    = 2'd2,
    FMT_ILLEGAL = 2'd3
  } fmt_e;

  // Two-operand opcode nibble to FunctionUnit code
  function automatic logic [15:0] fsFormatI(input logic [3:0] opc, input logic bw);
    case (opc)
      4'h4:    return bw ? FS_MOV_B  : FS_MOV;
      4'h5:    return bw ? FS_ADD_B  : FS_ADD;
      4'h6:    return bw ? FS_ADDC_B : FS_ADDC;
      4'h7:    return bw ? FS_SUBC_B : FS_SUBC;
      4'h8:    return bw ? FS_SUB_B  : FS_SUB;
      4'h9:    return bw ? FS_CMP_B  : FS_CMP;
      4'hA:    return bw ? FS_DADD_B : FS_DADD;
      4'hB:    return bw ? FS_BIT_B  : FS_BIT;
      4'hC:    return bw ? FS_BIC_B  : FS_BIC;
      4'hD:    return bw ? FS_BIS_B  : FS_BIS;
      4'hE:    return bw ? FS_XOR_B  : FS_XOR;
      4'hF:    return bw ? FS_AND_B  : FS_AND;
      default: return 16'h0000;
    endcase
  endfunction

  // Single-operand opcode to FunctionUnit code; byte forms of word-only ops
  // never reach here because the classifier marks them illegal
  function automatic logic [15:0] fsFormatII(input logic [2:0] opc, input logic bw);
    case (opc)
      OP2_RRC:  return bw ? FS_RRC_B  : FS_RRC;
      OP2_SWPB: return FS_SWPB;
      OP2_RRA:  return bw ? FS_RRA_B  : FS_RRA;
      OP2_SXT:  return FS_SXT;
      OP2_PUSH: return bw ? FS_PUSH_B : FS_PUSH;
      OP2_CALL: return FS_CALL;
      OP2_RETI: return FS_RETI;
      default:  return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder_classify.sv
// Purely combinational look at a first instruction word: which format it is,
// whether it is illegal, and how many extension words still have to follow.
module instr_classify
  import instr_decoder_pkg::*;
(
  input  logic [15:0] iw_i,
  output fmt_e        fmt_o,
  output logic        needSrc_o,
  output logic        needDst_o,
  output logic        illegal_o
);

  // R3 always and R2 in modes 10/11 are constant generators and take no word;
  // indexed mode and immediate (@PC+) need one
  function automatic logic srcNeedsExt(input logic [3:0] reg_, input logic [1:0] as_);
    return ((as_ == 2'b01) && (reg_ != 4'd3)) || ((as_ == 2'b11) && (reg_ == 4'd0));
  endfunction

  logic [2:0] op2;
  logic       byteForm;
  logic       wordOnly;

  assign op2      = iw_i[9:7];
  assign byteForm = iw_i[6];
  assign wordOnly = (op2 == OP2_SWPB) || (op2 == OP2_SXT) ||
                    (op2 == OP2_CALL) || (op2 == OP2_RETI);

  // Classify the word, then derive extension needs only for legal operand formats
  always_comb begin
    fmt_o     = FMT_ILLEGAL;
    needSrc_o = 1'b0;
    needDst_o = 1'b0;
    if (iw_i[15:12] >= 4'd4) begin
      fmt_o = FMT_I;
    end else if (iw_i[15:13] == 3'b001) begin
      fmt_o = FMT_JUMP;
    end else if (iw_i[15:10] == 6'b000100) begin
      if ((op2 == OP2_BAD) || (byteForm && wordOnly)) fmt_o = FMT_ILLEGAL;
      else                                            fmt_o = FMT_II;
    end
    case (fmt_o)
      FMT_I: begin
        needSrc_o = srcNeedsExt(iw_i[11:8], iw_i[5:4]);
        needDst_o = iw_i[7];
      end
      FMT_II: begin
        needSrc_o = srcNeedsExt(iw_i[3:0], iw_i[5:4]);
      end
      default: begin
        needSrc_o = 1'b0;
        needDst_o = 1'b0;
      end
    endcase
  end

  assign illegal_o = (fmt_o == FMT_ILLEGAL);

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder: accepts an instruction word plus up to two extension
// words, then holds the fully decoded instruction until execute takes it.
module instr_decoder
  import instr_decoder_pkg::*;
#(
  parameter logic [15:0] RESET_FS = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] iw,
  input  logic        iw_valid,
  output logic        iw_ready,
  output logic        issue_valid,
  input  logic        issue_ready,
  output logic [15:0] fs,
  output logic        bw,
  output logic [3:0]  src_reg,
  output logic [3:0]  dst_reg,
  output logic [1:0]  as_mode,
  output logic        ad_mode,
  output logic [15:0] src_ext,
  output logic [15:0] dst_ext,
  output logic        src_ext_vld,
  output logic        dst_ext_vld,
  output logic        is_jump,
  output logic [2:0]  jcond,
  output logic [15:0] jofs,
  output logic        illegal
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    SRC_EXT = 2'd1,
    DST_EXT = 2'd2,
    ISSUE   = 2'd3
  } state_e;

  state_e      state_q;
  logic        needDst_q;
  logic [15:0] fs_q, srcExt_q, dstExt_q, jofs_q;
  logic        bw_q, adMode_q, srcExtVld_q, dstExtVld_q, isJump_q, illegal_q;
  logic [3:0]  srcReg_q, dstReg_q;
  logic [1:0]  asMode_q;
  logic [2:0]  jcond_q;

  logic [15:0] fs_d, jofs_d;
  logic        bw_d, adMode_d, isJump_d, illegal_d;
  logic [3:0]  srcReg_d, dstReg_d;
  logic [1:0]  asMode_d;
  logic [2:0]  jcond_d;

  fmt_e fmt;
  logic needSrc, needDst, classIllegal;
  logic wordXfer;

  instr_classify uClassify (
    .iw_i      (iw),
    .fmt_o     (fmt),
    .needSrc_o (needSrc),
    .needDst_o (needDst),
    .illegal_o (classIllegal)
  );

  assign iw_ready    = (state_q != ISSUE);
  assign issue_valid = (state_q == ISSUE);
  assign wordXfer    = iw_valid && iw_ready;

  // Field decode of the word on iw, only captured when it arrives in FETCH
  always_comb begin
    fs_d      = RESET_FS;
    bw_d      = 1'b0;
    srcReg_d  = 4'd0;
    dstReg_d  = 4'd0;
    asMode_d  = 2'd0;
    adMode_d  = 1'b0;
    isJump_d  = 1'b0;
    jcond_d   = 3'd0;
    jofs_d    = 16'h0000;
    illegal_d = classIllegal;
    case (fmt)
      FMT_I: begin
        fs_d     = fsFormatI(iw[15:12], iw[6]);
        bw_d     = iw[6];
        srcReg_d = iw[11:8];
        adMode_d = iw[7];
        asMode_d = iw[5:4];
        dstReg_d = iw[3:0];
      end
      FMT_II: begin
        fs_d     = fsFormatII(iw[9:7], iw[6]);
        bw_d     = iw[6];
        srcReg_d = iw[3:0];
        dstReg_d = iw[3:0];
        asMode_d = iw[5:4];
      end
      FMT_JUMP: begin
        isJump_d = 1'b1;
        jcond_d  = iw[12:10];
        jofs_d   = {{5{iw[9]}}, iw[9:0], 1'b0};
      end
      default: begin
        fs_d = RESET_FS;
      end
    endcase
  end

  // Fetch/extension/issue sequencer with all decoded outputs held in registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      needDst_q   <= 1'b0;
      fs_q        <= RESET_FS;
      bw_q        <= 1'b0;
      srcReg_q    <= 4'd0;
      dstReg_q    <= 4'd0;
      asMode_q    <= 2'd0;
      adMode_q    <= 1'b0;
      srcExt_q    <= 16'h0000;
      dstExt_q    <= 16'h0000;
      srcExtVld_q <= 1'b0;
      dstExtVld_q <= 1'b0;
      isJump_q    <= 1'b0;
      jcond_q     <= 3'd0;
      jofs_q      <= 16'h0000;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (wordXfer) begin
            fs_q        <= fs_d;
            bw_q        <= bw_d;
            srcReg_q    <= srcReg_d;
            dstReg_q    <= dstReg_d;
            asMode_q    <= asMode_d;
            adMode_q    <= adMode_d;
            isJump_q    <= isJump_d;
            jcond_q     <= jcond_d;
            jofs_q      <= jofs_d;
            illegal_q   <= illegal_d;
            srcExt_q    <= 16'h0000;
            dstExt_q    <= 16'h0000;
            srcExtVld_q <= 1'b0;
            dstExtVld_q <= 1'b0;
            needDst_q   <= needDst;
            if (needSrc)      state_q <= SRC_EXT;
            else if (needDst) state_q <= DST_EXT;
            else              state_q <= ISSUE;
          end
        end
        SRC_EXT: begin
          if (wordXfer) begin
            srcExt_q    <= iw;
            srcExtVld_q <= 1'b1;
            state_q     <= needDst_q ? DST_EXT : ISSUE;
          end
        end
        DST_EXT: begin
          if (wordXfer) begin
            dstExt_q    <= iw;
            dstExtVld_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (issue_ready) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign fs          = fs_q;
  assign bw          = bw_q;
  assign src_reg     = srcReg_q;
  assign dst_reg     = dstReg_q;
  assign as_mode     = asMode_q;
  assign ad_mode     = adMode_q;
  assign src_ext     = srcExt_q;
  assign dst_ext     = dstExt_q;
  assign src_ext_vld = srcExtVld_q;
  assign dst_ext_vld = dstExtVld_q;
  assign is_jump     = isJump_q;
  assign jcond       = jcond_q;
  assign jofs        = jofs_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: directed cases followed by random
// instruction streams checked against a behavioural decode model.
module tb_instr_decoder;
  import instr_decoder_pkg::*;

  localparam logic [15:0] RESET_FS_EXP = 16'hDEAD;

  logic        clk;
  logic        rst_n;
  logic [15:0] iw;
  logic        iw_valid;
  logic        iw_ready;
  logic        issue_valid;
  logic        issue_ready;
  logic [15:0] fs;
  logic        bw;
  logic [3:0]  src_reg;
  logic [3:0]  dst_reg;
  logic [1:0]  as_mode;
  logic        ad_mode;
  logic [15:0] src_ext;
  logic [15:0] dst_ext;
  logic        src_ext_vld;
  logic        dst_ext_vld;
  logic        is_jump;
  logic [2:0]  jcond;
  logic [15:0] jofs;
  logic        illegal;

  int checks   = 0;
  int failures = 0;

  // kind: 0 two-operand, 1 single-operand, 2 jump, 3 illegal
  typedef struct {
    int          kind;
    logic [15:0] fs;
    logic        bw;
    logic [3:0]  srcReg;
    logic [3:0]  dstReg;
    logic [1:0]  asMode;
    logic        adMode;
    logic [2:0]  jcond;
    logic [15:0] jofs;
    int          needSrc;
    int          needDst;
  } exp_t;

  exp_t        curExp;
  logic [15:0] curSrcExt;
  logic [15:0] curDstExt;

  logic [15:0] fsWord[16];
  logic [15:0] fsByte[16];
  logic [15:0] fs2Word[8];
  logic [15:0] fs2Byte[8];
  bit          byteOk[8];

  instr_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .iw          (iw),
    .iw_valid    (iw_valid),
    .iw_ready    (iw_ready),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .fs          (fs),
    .bw          (bw),
    .src_reg     (src_reg),
    .dst_reg     (dst_reg),
    .as_mode     (as_mode),
    .ad_mode     (ad_mode),
    .src_ext     (src_ext),
    .dst_ext     (dst_ext),
    .src_ext_vld (src_ext_vld),
    .dst_ext_vld (dst_ext_vld),
    .is_jump     (is_jump),
    .jcond       (jcond),
    .jofs        (jofs),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Operand needs a word: indexed/absolute (mode 1) unless R3, immediate via PC
  function automatic int modelNeedsWord(input int r, input int as_);
    if (r == 3) return 0;
    if (r == 2 && as_ >= 2) return 0;
    if (as_ == 1) return 1;
    if (as_ == 3 && r == 0) return 1;
    return 0;
  endfunction

  function automatic exp_t modelDecode(input logic [15:0] w);
    exp_t e;
    int wi, top, op2, isByte, as_, rs, rd, ad, off;
    wi     = int'(w);
    top    = wi / 4096;
    op2    = (wi / 128) % 8;
    isByte = (wi / 64) % 2;
    as_    = (wi / 16) % 4;
    rs     = (wi / 256) % 16;
    rd     = wi % 16;
    ad     = (wi / 128) % 2;
    e = '{default: 0};
    e.fs = RESET_FS_EXP;
    e.kind = 3;
    if (top >= 4) begin
      e.kind    = 0;
      e.fs      = (isByte != 0) ? fsByte[top] : fsWord[top];
      e.bw      = 1'(isByte);
      e.srcReg  = 4'(rs);
      e.dstReg  = 4'(rd);
      e.asMode  = 2'(as_);
      e.adMode  = 1'(ad);
      e.needSrc = modelNeedsWord(rs, as_);
      e.needDst = ad;
    end else if (wi / 8192 == 1) begin
      e.kind  = 2;
      e.jcond = 3'((wi / 1024) % 8);
      off = wi % 1024;
      if (off >= 512) off = off - 1024;
      e.jofs = 16'(off * 2);
    end else if (wi / 1024 == 4) begin
      if (op2 != 7 && !(isByte != 0 && !byteOk[op2])) begin
        e.kind    = 1;
        e.fs      = (isByte != 0) ? fs2Byte[op2] : fs2Word[op2];
        e.bw      = 1'(isByte);
        e.srcReg  = 4'(rd);
        e.asMode  = 2'(as_);
        e.needSrc = modelNeedsWord(rd, as_);
      end
    end
    return e;
  endfunction

  // Present one word at a negedge; iw_ready must be high so it transfers next edge
  task automatic applyStimulus(input logic [15:0] w);
    iw       = w;
    iw_valid = 1'b1;
    checkOutput("iw_ready_on_word", 32'(iw_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    iw_valid = 1'b0;
    iw       = 16'($urandom);
  endtask

  task automatic checkFields();
    checkOutput("fs", 32'(fs), 32'(curExp.fs));
    checkOutput("illegal", 32'(illegal), (curExp.kind == 3) ? 32'd1 : 32'd0);
    checkOutput("is_jump", 32'(is_jump), (curExp.kind == 2) ? 32'd1 : 32'd0);
    checkOutput("src_ext_vld", 32'(src_ext_vld), 32'(curExp.needSrc));
    checkOutput("dst_ext_vld", 32'(dst_ext_vld), 32'(curExp.needDst));
    if (curExp.needSrc != 0) checkOutput("src_ext", 32'(src_ext), 32'(curSrcExt));
    if (curExp.needDst != 0) checkOutput("dst_ext", 32'(dst_ext), 32'(curDstExt));
    if (curExp.kind == 2) begin
      checkOutput("jcond", 32'(jcond), 32'(curExp.jcond));
      checkOutput("jofs", 32'(jofs), 32'(curExp.jofs));
    end
    if (curExp.kind == 0 || curExp.kind == 1) begin
      checkOutput("bw", 32'(bw), 32'(curExp.bw));
      checkOutput("src_reg", 32'(src_reg), 32'(curExp.srcReg));
      checkOutput("as_mode", 32'(as_mode), 32'(curExp.asMode));
    end
    if (curExp.kind == 0) begin
      checkOutput("dst_reg", 32'(dst_reg), 32'(curExp.dstReg));
      checkOutput("ad_mode", 32'(ad_mode), 32'(curExp.adMode));
    end
  endtask

  // Feed an instruction and the words the model says it needs, with random stalls
  task automatic issueInstr(input logic [15:0] w0, input logic [15:0] e1, input logic [15:0] e2);
    int nExt;
    int gap;
    curExp    = modelDecode(w0);
    curSrcExt = (curExp.needSrc != 0) ? e1 : 16'h0000;
    curDstExt = (curExp.needDst != 0) ? ((curExp.needSrc != 0) ? e2 : e1) : 16'h0000;
    nExt      = curExp.needSrc + curExp.needDst;
    applyStimulus(w0);
    for (int k = 0; k < nExt; k++) begin
      checkOutput("early_issue", 32'(issue_valid), 32'd0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(posedge clk);
        @(negedge clk);
        checkOutput("stall_iw_ready", 32'(iw_ready), 32'd1);
        checkOutput("stall_issue", 32'(issue_valid), 32'd0);
      end
      applyStimulus((k == 0) ? e1 : e2);
    end
    checkOutput("issue_valid", 32'(issue_valid), 32'd1);
    checkOutput("issue_iw_ready", 32'(iw_ready), 32'd0);
    checkFields();
  endtask

  // Hold execute off for a while (offering junk words), then let it accept
  task automatic releaseIssue(input int hold);
    for (int h = 0; h < hold; h++) begin
      iw          = 16'($urandom);
      iw_valid    = 1'b1;
      issue_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checkOutput("hold_issue_valid", 32'(issue_valid), 32'd1);
      checkOutput("hold_iw_ready", 32'(iw_ready), 32'd0);
      checkFields();
    end
    iw_valid    = 1'b0;
    issue_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    issue_ready = 1'b0;
    checkOutput("release_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("release_iw_ready", 32'(iw_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] w, e1, e2;
    int cls;

    fsWord[0] = 16'h0; fsWord[1] = 16'h0; fsWord[2] = 16'h0; fsWord[3] = 16'h0;
    fsByte[0] = 16'h0; fsByte[1] = 16'h0; fsByte[2] = 16'h0; fsByte[3] = 16'h0;
    fsWord[4]  = FS_MOV;  fsByte[4]  = FS_MOV_B;
    fsWord[5]  = FS_ADD;  fsByte[5]  = FS_ADD_B;
    fsWord[6]  = FS_ADDC; fsByte[6]  = FS_ADDC_B;
    fsWord[7]  = FS_SUBC; fsByte[7]  = FS_SUBC_B;
    fsWord[8]  = FS_SUB;  fsByte[8]  = FS_SUB_B;
    fsWord[9]  = FS_CMP;  fsByte[9]  = FS_CMP_B;
    fsWord[10] = FS_DADD; fsByte[10] = FS_DADD_B;
    fsWord[11] = FS_BIT;  fsByte[11] = FS_BIT_B;
    fsWord[12] = FS_BIC;  fsByte[12] = FS_BIC_B;
    fsWord[13] = FS_BIS;  fsByte[13] = FS_BIS_B;
    fsWord[14] = FS_XOR;  fsByte[14] = FS_XOR_B;
    fsWord[15] = FS_AND;  fsByte[15] = FS_AND_B;
    fs2Word[0] = FS_RRC;  fs2Byte[0] = FS_RRC_B;  byteOk[0] = 1'b1;
    fs2Word[1] = FS_SWPB; fs2Byte[1] = 16'h0;     byteOk[1] = 1'b0;
    fs2Word[2] = FS_RRA;  fs2Byte[2] = FS_RRA_B;  byteOk[2] = 1'b1;
    fs2Word[3] = FS_SXT;  fs2Byte[3] = 16'h0;     byteOk[3] = 1'b0;
    fs2Word[4] = FS_PUSH; fs2Byte[4] = FS_PUSH_B; byteOk[4] = 1'b1;
    fs2Word[5] = FS_CALL; fs2Byte[5] = 16'h0;     byteOk[5] = 1'b0;
    fs2Word[6] = FS_RETI; fs2Byte[6] = 16'h0;     byteOk[6] = 1'b0;
    fs2Word[7] = 16'h0;   fs2Byte[7] = 16'h0;     byteOk[7] = 1'b0;

    rst_n       = 1'b0;
    iw          = 16'h0000;
    iw_valid    = 1'b0;
    issue_ready = 1'b0;
    repeat (2) @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("rst_iw_ready", 32'(iw_ready), 32'd1);
    checkOutput("rst_fs", 32'(fs), 32'(RESET_FS_EXP));
    checkOutput("rst_illegal", 32'(illegal), 32'd0);
    checkOutput("rst_is_jump", 32'(is_jump), 32'd0);
    checkOutput("rst_src_ext_vld", 32'(src_ext_vld), 32'd0);
    checkOutput("rst_dst_ext_vld", 32'(dst_ext_vld), 32'd0);
    checkOutput("rst_src_reg", 32'(src_reg), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed: MOV R5,R6");
    issueInstr(16'h4506, 16'h0000, 16'h0000);
    checkOutput("mov_fs", 32'(fs), 32'(FS_MOV));
    checkOutput("mov_src_reg", 32'(src_reg), 32'd5);
    checkOutput("mov_dst_reg", 32'(dst_reg), 32'd6);
    releaseIssue(0);

    $display("[TB] directed: ADD with two extension words, held 3 cycles");
    issueInstr(16'h50B2, 16'h1234, 16'h0200);
    checkOutput("add_fs", 32'(fs), 32'(FS_ADD));
    checkOutput("add_src_ext", 32'(src_ext), 32'h1234);
    checkOutput("add_dst_ext", 32'(dst_ext), 32'h0200);
    releaseIssue(3);

    $display("[TB] directed: constant generator and jump");
    issueInstr(16'h4326, 16'hFFFF, 16'hFFFF);
    checkOutput("cg_as_mode", 32'(as_mode), 32'd2);
    checkOutput("cg_src_ext_vld", 32'(src_ext_vld), 32'd0);
    releaseIssue(1);
    issueInstr(16'h3C05, 16'h0000, 16'h0000);
    checkOutput("jmp_is_jump", 32'(is_jump), 32'd1);
    checkOutput("jmp_jcond", 32'(jcond), 32'd7);
    checkOutput("jmp_jofs", 32'(jofs), 32'h000A);
    checkOutput("jmp_fs", 32'(fs), 32'(RESET_FS_EXP));
    releaseIssue(0);

    $display("[TB] directed: illegal SWPB.B");
    issueInstr(16'h10C5, 16'h0000, 16'h0000);
    checkOutput("ill_illegal", 32'(illegal), 32'd1);
    checkOutput("ill_iw_ready", 32'(iw_ready), 32'd0);
    releaseIssue(2);

    $display("[TB] directed: reset mid-instruction");
    applyStimulus(16'h50B2);
    checkOutput("midrst_pending", 32'(issue_valid), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_iw_ready", 32'(iw_ready), 32'd1);
    checkOutput("midrst_issue_valid", 32'(issue_valid), 32'd0);
    checkOutput("midrst_fs", 32'(fs), 32'(RESET_FS_EXP));
    checkOutput("midrst_src_ext_vld", 32'(src_ext_vld), 32'd0);
    issueInstr(16'h4506, 16'h0000, 16'h0000);
    checkOutput("midrst_mov_fs", 32'(fs), 32'(FS_MOV));
    releaseIssue(0);

    $display("[TB] random instruction stream");
    for (int n = 0; n < 80; n++) begin
      w   = 16'($urandom);
      e1  = 16'($urandom);
      e2  = 16'($urandom);
      cls = $urandom_range(0, 3);
      if (cls == 0) begin
        if (w[15:12] < 4'd4) w[15:12] = 4'(4 + $urandom_range(0, 11));
      end else if (cls == 1) begin
        w[15:13] = 3'b001;
      end else if (cls == 2) begin
        w[15:10] = 6'b000100;
      end
      issueInstr(w, e1, e2);
      releaseIssue($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_decoder.md
INSTR_DECODER -- requirements
Module: instr_decoder

Interface
REQ-001 SHALL have parameter RESET_FS, default 16'hDEAD, the fs value driven when no instruction is held.
REQ-002 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have ports: iw  in  16  instruction or extension word; iw_valid  in  1  iw present; iw_ready  out  1  word accepted this cycle.
REQ-004 SHALL have ports: issue_valid  out  1  decoded instruction held; issue_ready  in  1  execute stage accepts.
REQ-005 SHALL have ports: fs  out  16  FunctionUnit select code; bw  out  1  byte op; src_reg, dst_reg  out  4 each; as_mode  out  2; ad_mode  out  1.
REQ-006 SHALL have ports: src_ext, dst_ext  out  16 each  extension words; src_ext_vld, dst_ext_vld  out  1 each.
REQ-007 SHALL have ports: is_jump  out  1; jcond  out  3; jofs  out  16  sign-extended offset x2; illegal  out  1.

Function
REQ-008 SHALL implement states FETCH, SRC_EXT, DST_EXT, ISSUE; a word transfers only when iw_valid & iw_ready.
REQ-009 SHALL drive iw_ready=1 in FETCH, SRC_EXT and DST_EXT, and 0 in ISSUE.
REQ-010 SHALL decode in FETCH: iw[15:12]>=4 Format I; iw[15:13]=001 jump; iw[15:10]=000100 Format II; else illegal.
REQ-011 SHALL need a src extension when (As=01 and src!=R3) or (As=11 and src=R0); R3, and R2 with As=10/11, are constant generators needing no word.
REQ-012 SHALL need a dst extension for Format I when Ad=1; Format II uses only the src rule on its single register.
REQ-013 SHALL go FETCH->SRC_EXT when src ext is needed, else ->DST_EXT when dst ext is needed, else ->ISSUE; SRC_EXT->DST_EXT or ->ISSUE; DST_EXT->ISSUE.
REQ-014 SHALL assert issue_valid the cycle after the final word is accepted; latency = 1 cycle per word.
REQ-015 SHALL hold every output stable in ISSUE until issue_ready, then go to ISSUE->FETCH, with no overlap with the next fetch.
REQ-016 SHALL map opcodes to FS constants, selecting the byte code when bw=1; BIT/CMP SHALL use their own codes.
REQ-017 SHALL flag illegal=1 and go FETCH->ISSUE directly with no ext fetch for: Format II opc=111, byte forms of SWPB/SXT/CALL/RETI, and iw[15:12]=0000 without Format II.
REQ-018 SHALL set, for jumps: is_jump=1, jcond=iw[12:10], jofs={{5{iw[9]}},iw[9:0],1'b0}, fs=RESET_FS.
REQ-019 SHALL keep iw_valid low with no state change while waiting in FETCH or an EXT state, so stalls are indefinite.

Reset
REQ-020 SHALL on rst_n=0 at a clock edge enter FETCH and clear issue_valid, illegal, is_jump, the ext valids and all fields, with fs=RESET_FS.
REQ-021 SHALL discard a partially fetched instruction on reset; the first word accepted after reset is decoded as an instruction.

Structure
REQ-022 SHALL take FS codes from the shared FSparams package; state encoding and the ext-needed rules SHALL be local.
REQ-023 SHALL place the combinational word classifier (format, ext needs, illegal) in sub-module instr_classify.

Verification
REQ-024 SHALL check: 0x4506 -> one cycle later issue_valid, fs=MOV, src_reg=5, dst_reg=6, as_mode=0, ad_mode=0, no ext.
REQ-025 SHALL check: 0x50B2, 0x1234, 0x0200 -> fs=ADD, src_ext=0x1234, dst_ext=0x0200, both ext valids set, issue after the third word.
REQ-026 SHALL check: 0x4326 (#2 via R3) -> issue after one word, no ext, as_mode=2; 0x3C05 -> is_jump=1, jcond=7, jofs=0x000A.
REQ-027 SHALL check: 0x10C5 (SWPB.B) -> illegal=1, no ext fetch, iw_ready=0 during ISSUE.
REQ-028 SHALL check: issue_ready low 3 cycles -> outputs constant, iw_ready=0; release -> FETCH the next cycle.
REQ-029 SHALL check: rst_n low after 0x50B2 -> FETCH; 0x4506 then decodes as MOV.
